dvsd_pe_seq: RTL and testbench
==============================

// Module: dvsd_pe_seq
// PURPOSE
//  Parametrised, registered successor to the 8:3 priority encoder dvsd_pe.
//  Captures request pulses on N inputs into sticky pending bits and issues
//  them one at a time as encoded indices over a valid/ready handshake.
//  Two arbitration modes: fixed priority (MSB wins) and round-robin.
//  Sits between event/interrupt sources and a single-index consumer.
// PARAMETERS
//  N     8          number of request inputs, N >= 2
//  W     $clog2(N)  output index width (localparam, derived from N)
//  MODE  0          0 = fixed priority, highest index wins; 1 = round-robin
// PORTS
//  clk        in   1  clock, rising edge
//  rst        in   1  asynchronous reset, active high
//  en         in   1  capture enable; req is ignored when 0
//  flush      in   1  synchronous clear of pend and output slot
//  req        in   N  request pulses, one bit per source
//  out_ready  in   1  consumer accepts out this cycle
//  out        out  W  issued index, valid when out_valid=1
//  out_valid  out  1  out holds an unaccepted index
//  gs         out  1  group select; equals out_valid
//  eno        out  1  enable-out: en & ~out_valid & ~|pend (combinational)
//  pend       out  N  pending, not-yet-issued request bits
//  drop       out  1  one-cycle pulse: a request merged into an already pending bit
// BEHAVIOUR
//  Reset (async, rst=1): out=0, out_valid=0, pend=0, drop=0, rr_ptr=0.
//   gs=0. eno=0, because en is gated by reset.
//  Definitions: cand = pend | (en ? req : 0); load = ~out_valid | (out_valid & out_ready).
//  Selection from cand:
//   MODE 0: highest set index of cand.
//   MODE 1: first set index scanning upward from rr_ptr, wrapping N-1 -> 0.
//  Each rising edge (flush=0):
//   load & |cand: out <= sel, out_valid <= 1, pend <= cand & ~onehot(sel);
//     MODE 1 also sets rr_ptr <= (sel+1) mod N.
//   load & ~|cand: out_valid <= 0, out holds its last value, pend <= cand.
//   ~load (valid & ~ready): out and out_valid hold; pend <= cand.
//   Out never changes while out_valid=1 and out_ready=0, even if a
//     higher-priority request arrives.
//  Latency: a req sampled at edge k with a free slot gives out_valid=1 after edge k.
//  Throughput: one index per cycle with out_ready held at 1.
//  drop <= |(en ? req : 0) & pend, using the pre-edge pend.
//   Merged requests are issued once only.
//  flush=1: pend <= 0, out_valid <= 0, drop <= 0. rr_ptr holds.
//   Requests in the same cycle are discarded. flush has priority over load.
//  en=0: no capture. Pending bits keep issuing and the handshake continues.
//  Same-cycle set and issue of a bit: the bit goes to out and is not re-pended.
//  rst asserted mid-operation: everything clears immediately.
//   An in-flight index is lost.
//  Non-power-of-two N: sel never exceeds N-1, and rr_ptr wraps at N, not 2^W.
// TESTING
//  1 Reset: rst=1 mid-burst -> out=0, out_valid=0, gs=0, pend=0, drop=0 at once.
//  2 Walk, MODE0, en=1, ready=1: req=8'h01,02,..,80, one per cycle
//     -> out=0..7 one cycle later each, out_valid=1.
//  3 Burst, MODE0: req=8'hA5 for one cycle, ready=1 -> out 7,5,2,0 on consecutive
//     cycles, then out_valid=0 and eno=1.
//  4 Backpressure: out=3 valid with ready=0, then req=8'h40 -> out stays 3;
//     raise ready -> out=6 next cycle.
//  5 Drop: bit 2 pending, req=8'h04 again -> drop=1 for 1 cycle; index 2 issued once.
//  6 Fairness: req=8'h03 held, ready=1. MODE0 -> out 1,1,1,... with drop pulses.
//     MODE1 -> out 0,1,0,1,...

Source files
------------

// File: rtl/dvsd_pe_seq_if.sv
// dvsd_pe_seq_if: request/issue bus between event sources and dvsd_pe_seq
// Ports: en, flush, req[N], out_ready in to the encoder; out[W], out_valid, gs,
// eno, pend[N], drop back from it. master = source/consumer side, slave = encoder.
interface dvsd_pe_seq_if #(parameter int N = 8);
  localparam int W = $clog2(N);
  logic en, flush, out_ready, out_valid, gs, eno, drop;
  logic [N-1:0] req, pend;
  logic [W-1:0] out;
  modport master(output en, flush, req, out_ready, input out, out_valid, gs, eno, pend, drop);
  modport slave(input en, flush, req, out_ready, output out, out_valid, gs, eno, pend, drop);
endinterface

// File: rtl/dvsd_pe_seq.sv
// dvsd_pe_seq: sticky-request priority encoder issuing one index per valid/ready beat
// Ports: clk, rst (async, active high); bus (slave) carries en, flush, req,
// out_ready in and out, out_valid, gs, eno, pend, drop out.
module dvsd_pe_seq #(
  parameter int N = 8,
  parameter int MODE = 0
) (
  input logic clk,
  input logic rst,
  dvsd_pe_seq_if.slave bus
);
  localparam int W = $clog2(N);
  logic [N-1:0] pend_q, capt, cand, rot;
  logic [2*N-1:0] dbl;
  logic [W-1:0] out_q, rr_ptr, hi, lo, sel, nxt;
  logic [W:0] sum;
  logic valid_q, drop_q, load;
  assign capt = bus.en ? bus.req : '0;
  assign cand = pend_q | capt;
  assign load = ~valid_q | bus.out_ready;
  // Rotating by rr_ptr turns "first set bit at or above rr_ptr, wrapping" into a lowest-bit search.
  assign dbl = {cand, cand} >> rr_ptr;
  assign rot = dbl[N-1:0];
  always_comb begin
    hi = '0;
    lo = '0;
    for (int i = 0; i < N; i++) if (cand[i]) hi = W'(i);
    for (int i = N - 1; i >= 0; i--) if (rot[i]) lo = W'(i);
  end
  // Wrap the rotated offset back at N, not 2^W, so odd N never yields an out-of-range index.
  assign sum = {1'b0, rr_ptr} + {1'b0, lo};
  assign sel = (MODE == 0) ? hi : (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : W'(sum);
  assign nxt = (sel == W'(N - 1)) ? '0 : sel + 1'b1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      valid_q <= 1'b0;
      pend_q <= '0;
      drop_q <= 1'b0;
      rr_ptr <= '0;
    end else if (bus.flush) begin
      pend_q <= '0;
      valid_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= |(capt & pend_q);
      if (load && |cand) begin
        out_q <= sel;
        valid_q <= 1'b1;
        pend_q <= cand & ~({{(N-1){1'b0}}, 1'b1} << sel);
        if (MODE == 1) rr_ptr <= nxt;
      end else begin
        pend_q <= cand;
        if (load) valid_q <= 1'b0;
      end
    end
  end
  assign bus.out = out_q;
  assign bus.out_valid = valid_q;
  assign bus.gs = valid_q;
  assign bus.pend = pend_q;
  assign bus.drop = drop_q;
  assign bus.eno = bus.en & ~rst & ~valid_q & ~|pend_q;
endmodule

// File: tb/tb_dvsd_pe_seq.sv
// tb_dvsd_pe_seq: directed vector bench for dvsd_pe_seq in both arbitration modes
module tb_dvsd_pe_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dvsd_pe_seq_if #(.N(8)) b0();
  dvsd_pe_seq_if #(.N(8)) b1();
  dvsd_pe_seq_if #(.N(5)) b2();
  dvsd_pe_seq #(.N(8), .MODE(0)) u0(.clk(clk), .rst(rst), .bus(b0.slave));
  dvsd_pe_seq #(.N(8), .MODE(1)) u1(.clk(clk), .rst(rst), .bus(b1.slave));
  dvsd_pe_seq #(.N(5), .MODE(1)) u2(.clk(clk), .rst(rst), .bus(b2.slave));
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic en, flush;
    logic [7:0] req;
    logic ready;
    logic [2:0] out;
    logic valid;
    logic [7:0] pend;
    logic drop, eno;
  } vec_t;
  vec_t tv[$];
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    b0.en = 0; b0.flush = 0; b0.req = '0; b0.out_ready = 0;
    b1.en = 0; b1.flush = 0; b1.req = '0; b1.out_ready = 0;
    b2.en = 0; b2.flush = 0; b2.req = '0; b2.out_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    vec_t v;
    int o1[6] = '{0, 1, 0, 1, 0, 1};
    do_reset();
    rst = 1'b1;
    b0.en = 1;
    #1;
    chk("rst.out", int'(b0.out), 0);
    chk("rst.valid", int'(b0.out_valid), 0);
    chk("rst.gs", int'(b0.gs), 0);
    chk("rst.pend", int'(b0.pend), 0);
    chk("rst.eno", int'(b0.eno), 0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 8; i++) tv.push_back('{1, 0, 8'(1 << i), 1, 3'(i), 1, 8'h00, 0, 0});
    tv.push_back('{1, 0, 8'hA5, 1, 3'd7, 1, 8'h25, 0, 0});
    tv.push_back('{1, 0, 8'h00, 1, 3'd5, 1, 8'h05, 0, 0});
    tv.push_back('{1, 0, 8'h00, 1, 3'd2, 1, 8'h01, 0, 0});
    tv.push_back('{1, 0, 8'h00, 1, 3'd0, 1, 8'h00, 0, 0});
    tv.push_back('{1, 0, 8'h00, 1, 3'd0, 0, 8'h00, 0, 1});
    tv.push_back('{1, 0, 8'h08, 1, 3'd3, 1, 8'h00, 0, 0});
    tv.push_back('{1, 0, 8'h40, 0, 3'd3, 1, 8'h40, 0, 0});
    tv.push_back('{1, 0, 8'h00, 1, 3'd6, 1, 8'h00, 0, 0});
    tv.push_back('{1, 0, 8'h00, 1, 3'd6, 0, 8'h00, 0, 1});
    tv.push_back('{1, 0, 8'h0C, 1, 3'd3, 1, 8'h04, 0, 0});
    tv.push_back('{1, 0, 8'h04, 0, 3'd3, 1, 8'h04, 1, 0});
    tv.push_back('{1, 0, 8'h00, 1, 3'd2, 1, 8'h00, 0, 0});
    tv.push_back('{1, 0, 8'h00, 1, 3'd2, 0, 8'h00, 0, 1});
    tv.push_back('{1, 0, 8'h30, 1, 3'd5, 1, 8'h10, 0, 0});
    tv.push_back('{1, 1, 8'h01, 1, 3'd5, 0, 8'h00, 0, 1});
    tv.push_back('{0, 0, 8'hFF, 1, 3'd5, 0, 8'h00, 0, 0});
    @(negedge clk);
    for (int i = 0; i < tv.size(); i++) begin
      v = tv[i];
      b0.en = v.en; b0.flush = v.flush; b0.req = v.req; b0.out_ready = v.ready;
      step();
      chk($sformatf("vec%0d.out", i), int'(b0.out), int'(v.out));
      chk($sformatf("vec%0d.valid", i), int'(b0.out_valid), int'(v.valid));
      chk($sformatf("vec%0d.gs", i), int'(b0.gs), int'(v.valid));
      chk($sformatf("vec%0d.pend", i), int'(b0.pend), int'(v.pend));
      chk($sformatf("vec%0d.drop", i), int'(b0.drop), int'(v.drop));
      chk($sformatf("vec%0d.eno", i), int'(b0.eno), int'(v.eno));
    end
    do_reset();
    b0.en = 1; b0.out_ready = 1; b0.req = 8'hA5;
    step();
    chk("midrst.pre_out", int'(b0.out), 7);
    b0.req = '0;
    #2 rst = 1'b1;
    #1;
    chk("midrst.out", int'(b0.out), 0);
    chk("midrst.valid", int'(b0.out_valid), 0);
    chk("midrst.gs", int'(b0.gs), 0);
    chk("midrst.pend", int'(b0.pend), 0);
    chk("midrst.drop", int'(b0.drop), 0);
    chk("midrst.eno", int'(b0.eno), 0);
    @(negedge clk) rst = 1'b0;
    b0.en = 1; b0.out_ready = 1; b0.req = 8'h03;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("fair0.%0d.out", i), int'(b0.out), 1);
      chk($sformatf("fair0.%0d.drop", i), int'(b0.drop), i == 0 ? 0 : 1);
    end
    b1.en = 1; b1.out_ready = 1; b1.req = 8'h03;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("fair1.%0d.out", i), int'(b1.out), o1[i]);
      chk($sformatf("fair1.%0d.drop", i), int'(b1.drop), i == 0 ? 0 : 1);
    end
    b1.req = '0;
    step();
    chk("fair1.tail.out", int'(b1.out), 0);
    step();
    chk("fair1.idle.valid", int'(b1.out_valid), 0);
    do_reset();
    b2.en = 1; b2.out_ready = 1; b2.req = 5'h11;
    step();
    chk("n5.a.out", int'(b2.out), 0);
    chk("n5.a.pend", int'(b2.pend), 5'h10);
    b2.req = '0;
    step();
    chk("n5.b.out", int'(b2.out), 4);
    b2.req = 5'h06;
    step();
    chk("n5.c.out", int'(b2.out), 1);
    chk("n5.c.pend", int'(b2.pend), 5'h04);
    b2.req = '0;
    step();
    chk("n5.d.out", int'(b2.out), 2);
    step();
    chk("n5.e.valid", int'(b2.out_valid), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
